// File: rtl/combination_lock_sequencer_if.sv
// Keypad-side bundle for the combination lock: guessed digits in, lock status out.
// The driver (keypad front end) uses master; the lock checker uses slave.
interface combination_lock_sequencer_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int MAX_TRIES  = 3
) ();
    localparam int CNT_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [NUM_DIGITS*DIGIT_W-1:0] combination;
    logic [DIGIT_W-1:0]            digit_guess;
    logic                          digit_valid;
    logic                          clear;
    logic                          unlocked;
    logic                          locked_out;
    logic                          fail_pulse;
    logic [CNT_W-1:0]              digit_count;
    logic [TRY_W-1:0]              tries_left;

    modport master (
        output combination, digit_guess, digit_valid, clear,
        input  unlocked, locked_out, fail_pulse, digit_count, tries_left
    );

    modport slave (
        input  combination, digit_guess, digit_valid, clear,
        output unlocked, locked_out, fail_pulse, digit_count, tries_left
    );
endinterface

// File: rtl/combination_lock_sequencer.sv
// Multi-digit combination checker: accumulates per-digit matches, unlocks on a full
// correct attempt, counts failures and enforces a timed lockout after too many.
module combination_lock_sequencer #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    combination_lock_sequencer_if.slave   bus
);
    localparam int CNT_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int LCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   digit_count_q, digit_count_d;
    logic               match_q, match_d;
    logic [TRY_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               unlocked_q, unlocked_d;
    logic               locked_out_q, locked_out_d;
    logic               fail_pulse_q, fail_pulse_d;
    logic [TRY_W-1:0]   tries_left_q, tries_left_d;

    logic [DIGIT_W-1:0] digit_arr [NUM_DIGITS];
    logic               guess_ok;
    logic               final_digit;

    // The combination is compared live, so just slice it into digits.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = bus.combination[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    assign guess_ok    = (bus.digit_guess == digit_arr[digit_count_q]);
    assign final_digit = (digit_count_q == CNT_W'(NUM_DIGITS - 1));

    always_comb begin
        state_d       = state_q;
        digit_count_d = digit_count_q;
        match_d       = match_q;
        fail_cnt_d    = fail_cnt_q;
        lock_cnt_d    = lock_cnt_q;
        fail_pulse_d  = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (bus.clear) begin
                    digit_count_d = '0;
                    match_d       = 1'b1;
                end else if (bus.digit_valid) begin
                    if (final_digit) begin
                        digit_count_d = '0;
                        match_d       = 1'b1;
                        if (match_q && guess_ok) begin
                            state_d    = ST_UNLOCKED;
                            fail_cnt_d = '0;
                        end else begin
                            fail_pulse_d = 1'b1;
                            // Parking the fail count at MAX makes tries_left read 0 in lockout.
                            if (fail_cnt_q == TRY_W'(MAX_TRIES - 1)) begin
                                state_d    = ST_LOCKOUT;
                                fail_cnt_d = TRY_W'(MAX_TRIES);
                                lock_cnt_d = LCK_W'(LOCKOUT_CYCLES - 1);
                            end else begin
                                fail_cnt_d = fail_cnt_q + TRY_W'(1);
                            end
                        end
                    end else begin
                        digit_count_d = digit_count_q + CNT_W'(1);
                        match_d       = match_q & guess_ok;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (bus.clear) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d    = ST_ENTRY;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LCK_W'(1);
                end
            end
            default: begin
                state_d       = ST_ENTRY;
                digit_count_d = '0;
                match_d       = 1'b1;
                fail_cnt_d    = '0;
            end
        endcase

        unlocked_d   = (state_d == ST_UNLOCKED);
        locked_out_d = (state_d == ST_LOCKOUT);
        tries_left_d = TRY_W'(MAX_TRIES) - fail_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ENTRY;
            digit_count_q <= '0;
            match_q       <= 1'b1;
            fail_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            unlocked_q    <= 1'b0;
            locked_out_q  <= 1'b0;
            fail_pulse_q  <= 1'b0;
            tries_left_q  <= TRY_W'(MAX_TRIES);
        end else begin
            state_q       <= state_d;
            digit_count_q <= digit_count_d;
            match_q       <= match_d;
            fail_cnt_q    <= fail_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            unlocked_q    <= unlocked_d;
            locked_out_q  <= locked_out_d;
            fail_pulse_q  <= fail_pulse_d;
            tries_left_q  <= tries_left_d;
        end
    end

    assign bus.unlocked    = unlocked_q;
    assign bus.locked_out  = locked_out_q;
    assign bus.fail_pulse  = fail_pulse_q;
    assign bus.digit_count = digit_count_q;
    assign bus.tries_left  = tries_left_q;
endmodule
